// File: rtl/ahb_flash_reader.sv
// rtl/ahb_flash_reader.sv - AHB-Lite read-only window onto a quad-output SPI flash
// Optional one-word read buffer enabled by FLASH_READER_BUF_EN.
module ahb_flash_reader #(
  parameter int DUMMY_CYCLES = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        fm_sck,
  output logic        fm_ce_n,
  input  logic [3:0]  fm_din,
  output logic [3:0]  fm_dout,
  output logic [3:0]  fm_douten
);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_t;

  localparam logic [4:0] LAST_DUMMY = 5'(DUMMY_CYCLES - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] tx_sr;
  logic [27:0] rx_sr;
  logic [31:0] rx_word;
  logic [31:0] cmd_word;
  logic        accept;
  logic        hit;
  logic        rd_start;
  logic        fetch_end;
  logic        unused_ok;

  assign accept    = HSEL && HREADY && HTRANS[1];
  assign cmd_word  = {8'h6B, HADDR[23:2], 2'b00};
  assign rx_word   = {rx_sr, fm_din};
  assign rd_start  = accept && !HWRITE && !hit;
  assign fetch_end = (state == S_DATA) && fm_sck && (cnt == 5'd7);
  assign unused_ok = ^{HTRANS[0], HSIZE, HWDATA, HADDR[31:24], HADDR[1:0]};

`ifdef FLASH_READER_BUF_EN
  // HRDATA always holds the last fetched word, so it doubles as the buffer data.
  logic        buf_valid;
  logic [21:0] buf_tag;

  assign hit = buf_valid && (buf_tag == HADDR[23:2]);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
    end else if ((state == S_IDLE || state == S_DONE) && rd_start) begin
      buf_valid <= 1'b0;
      buf_tag   <= HADDR[23:2];
    end else if (fetch_end) begin
      buf_valid <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      fm_sck    <= 1'b0;
      fm_ce_n   <= 1'b1;
      fm_dout   <= '0;
      fm_douten <= '0;
      HREADYOUT <= 1'b1;
      HRDATA    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state     <= S_IDLE;
          fm_sck    <= 1'b0;
          fm_ce_n   <= 1'b1;
          fm_dout   <= '0;
          fm_douten <= '0;
          HREADYOUT <= 1'b1;
          if (rd_start) begin
            state     <= S_CMD;
            cnt       <= '0;
            tx_sr     <= {cmd_word[30:0], 1'b0};
            fm_dout   <= {3'b000, cmd_word[31]};
            fm_douten <= 4'b0001;
            fm_ce_n   <= 1'b0;
            HREADYOUT <= 1'b0;
          end
        end
        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          fm_sck <= ~fm_sck;
          // All bookkeeping happens on the edge that closes an SCK-high cycle.
          if (fm_sck) begin
            cnt <= cnt + 5'd1;
            if (state == S_CMD || state == S_ADDR) begin
              fm_dout <= {3'b000, tx_sr[31]};
              tx_sr   <= {tx_sr[30:0], 1'b0};
            end
            if (state == S_DATA) rx_sr <= rx_word[27:0];
            case (state)
              S_CMD: if (cnt == 5'd7) begin
                state <= S_ADDR;
                cnt   <= '0;
              end
              S_ADDR: if (cnt == 5'd23) begin
                state     <= (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
                cnt       <= '0;
                fm_dout   <= '0;
                fm_douten <= '0;
              end
              S_DUMMY: if (cnt == LAST_DUMMY) begin
                state <= S_DATA;
                cnt   <= '0;
              end
              S_DATA: if (cnt == 5'd7) begin
                state     <= S_DONE;
                cnt       <= '0;
                fm_ce_n   <= 1'b1;
                HREADYOUT <= 1'b1;
                HRDATA    <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
              end
              default: ;
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_flash_reader.sv
// tb/tb_ahb_flash_reader.sv - directed bench for ahb_flash_reader (DUMMY_CYCLES 8 and 0)
// Buffer expectations follow FLASH_READER_BUF_EN when it is defined.
module tb_ahb_flash_reader;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        hsel = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b010;
  logic        HWRITE = 1'b0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic        sel = 1'b0;
  logic [3:0]  din_m = '0;

  logic        rdy8, rdy0, sck8, sck0, ce8, ce0;
  logic [31:0] rdata8, rdata0;
  logic [3:0]  dout8, dout0, douten8, douten0;
  logic        rdy, sck_m, ce_m;
  logic [31:0] rdata;
  logic [3:0]  dout_m, douten_m;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0]  mem [0:511];
  int          edges = 0;
  int          hi_run = 0;
  int          last_gap = 0;
  int          fetches = 0;
  logic [31:0] cap = '0;

  always #5 HCLK = ~HCLK;

  ahb_flash_reader #(.DUMMY_CYCLES(8)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel && !sel), .HREADY(rdy8), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(rdy8), .HRDATA(rdata8), .fm_sck(sck8), .fm_ce_n(ce8),
    .fm_din(din_m), .fm_dout(dout8), .fm_douten(douten8)
  );

  ahb_flash_reader #(.DUMMY_CYCLES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel && sel), .HREADY(rdy0), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(rdy0), .HRDATA(rdata0), .fm_sck(sck0), .fm_ce_n(ce0),
    .fm_din(din_m), .fm_dout(dout0), .fm_douten(douten0)
  );

  assign rdy      = sel ? rdy0 : rdy8;
  assign rdata    = sel ? rdata0 : rdata8;
  assign sck_m    = sel ? sck0 : sck8;
  assign ce_m     = sel ? ce0 : ce8;
  assign dout_m   = sel ? dout0 : dout8;
  assign douten_m = sel ? douten0 : douten8;

  // Flash model: reads pin values from before each HCLK edge, drives data nibbles with NBA.
  always @(posedge HCLK) begin
    int dm, idx, a;
    logic [7:0] b;
    dm = sel ? 0 : 8;
    if (ce_m) begin
      edges = 0;
      hi_run++;
    end else begin
      if (hi_run != 0) begin
        last_gap = hi_run;
        fetches++;
      end
      hi_run = 0;
      if (sck_m) begin
        if (edges < 32) cap = {cap[30:0], dout_m[0]};
        edges++;
        if (edges >= 32 + dm && edges < 40 + dm) begin
          idx = edges - 32 - dm;
          a = (int'(cap[8:0]) + idx / 2) % 512;
          b = mem[a];
          din_m <= (idx % 2 == 0) ? b[7:4] : b[3:0];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic ahb_read(input logic [31:0] addr, input bit pipe, output int lat, output logic [31:0] data);
    if (!pipe) begin
      @(posedge HCLK); #1;
    end
    hsel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge HCLK); #1;
    hsel = 1'b0; HTRANS = 2'b00;
    lat = 1;
    while (!rdy && lat < 400) begin
      @(posedge HCLK); #1;
      lat++;
    end
    data = rdata;
  endtask

  initial begin
    int lat, lat2, f0;
    logic [31:0] d, d2;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    mem[8] = 8'hA1; mem[9] = 8'hB2; mem[10] = 8'hC3; mem[11] = 8'hD4;
    mem[32] = 8'h5A; mem[33] = 8'h6B; mem[34] = 8'h7C; mem[35] = 8'h8D;
    mem[36] = 8'hEF; mem[37] = 8'hCD; mem[38] = 8'hAB; mem[39] = 8'h90;
    mem[9'h104] = 8'h11; mem[9'h105] = 8'h22; mem[9'h106] = 8'h33; mem[9'h107] = 8'h44;

    repeat (3) @(posedge HCLK);
    #1;
    check("rst_ready", {31'b0, rdy}, 32'd1);
    check("rst_ce_n", {31'b0, ce_m}, 32'd1);
    check("rst_sck", {31'b0, sck_m}, 32'd0);
    check("rst_douten", {28'b0, douten_m}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    HRESETn = 1'b1;

    ahb_read(32'h0000_0104, 1'b0, lat, d);
    check("rd104_lat", lat, 97);
    check("rd104_data", d, 32'h4433_2211);
    check("rd104_cmd", {24'b0, cap[31:24]}, 32'h6B);
    check("rd104_addr", {8'b0, cap[23:0]}, 32'h0000_0104);

    f0 = fetches;
    @(posedge HCLK); #1;
    hsel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h10; HWDATA = 32'hDEAD_BEEF;
    @(posedge HCLK); #1;
    hsel = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    check("wr_ready", {31'b0, rdy}, 32'd1);
    repeat (5) @(posedge HCLK);
    #1;
    check("wr_ce_n", {31'b0, ce_m}, 32'd1);
    check("wr_no_fetch", fetches, f0);
    check("wr_rdata_kept", rdata, 32'h4433_2211);

    f0 = fetches;
    ahb_read(32'h0, 1'b0, lat, d);
    ahb_read(32'h8, 1'b1, lat2, d2);
    check("b2b_lat0", lat, 97);
    check("b2b_data0", d, 32'h0403_0201);
    check("b2b_lat1", lat2, 97);
    check("b2b_data1", d2, 32'hD4C3_B2A1);
    check("b2b_addr1", {8'b0, cap[23:0]}, 32'h8);
    check("b2b_ce_gap", last_gap, 1);
    check("b2b_fetches", fetches - f0, 2);

    @(posedge HCLK); #1;
    hsel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h104;
    @(posedge HCLK); #1;
    hsel = 1'b0; HTRANS = 2'b00;
    repeat (30) @(posedge HCLK);
    #1;
    check("mid_in_fetch", {31'b0, ce_m}, 32'd0);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    check("mid_rst_ce_n", {31'b0, ce_m}, 32'd1);
    check("mid_rst_sck", {31'b0, sck_m}, 32'd0);
    check("mid_rst_ready", {31'b0, rdy}, 32'd1);
    check("mid_rst_rdata", rdata, 32'h0);
    HRESETn = 1'b1;
    ahb_read(32'h104, 1'b0, lat, d);
    check("post_rst_lat", lat, 97);
    check("post_rst_data", d, 32'h4433_2211);

    ahb_read(32'h20, 1'b0, lat, d);
    check("buf20_lat", lat, 97);
    check("buf20_data", d, 32'h8D7C_6B5A);
    f0 = fetches;
    ahb_read(32'h22, 1'b0, lat, d);
`ifdef FLASH_READER_BUF_EN
    check("buf22_lat", lat, 1);
    check("buf22_fetches", fetches - f0, 0);
`else
    check("buf22_lat", lat, 97);
    check("buf22_fetches", fetches - f0, 1);
`endif
    check("buf22_data", d, 32'h8D7C_6B5A);
    ahb_read(32'h24, 1'b0, lat, d);
    check("buf24_lat", lat, 97);
    check("buf24_data", d, 32'h90AB_CDEF);

    sel = 1'b1;
    ahb_read(32'h104, 1'b0, lat, d);
    check("d0_lat", lat, 81);
    check("d0_data", d, 32'h4433_2211);
    check("d0_addr", {8'b0, cap[23:0]}, 32'h0000_0104);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
